// File: rtl/q_hit_buffer.sv
// Show-ahead hit FIFO for the Q extractor. It tags accepted charges with a timestamp
// and a sequence number, and counts dropped hits instead of back-pressuring the extractor.
module q_hit_buffer #(
  parameter int BITS       = 31,
  parameter int TS_BITS    = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic signed [BITS-1:0]   q_in,
  input  logic signed [BITS-1:0]   q_min,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [BITS-1:0]   out_q,
  output logic [TS_BITS-1:0]       out_ts,
  output logic [CNT_BITS-1:0]      out_seq,
  output logic [DEPTH_LOG2:0]      fill,
  output logic [CNT_BITS-1:0]      ovf_drops,
  output logic [CNT_BITS-1:0]      thr_drops
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = BITS + TS_BITS + CNT_BITS;

  logic [TS_BITS-1:0]  ts_q, ts_d;
  logic [CNT_BITS-1:0] seq_q, seq_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] ovf_q, ovf_d, thr_q, thr_d;
  logic [EW-1:0]       mem_q [DEPTH];
  logic [EW-1:0]       head;
  logic                empty, full, below, pop, push;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    below    = (q_in < q_min);
    pop      = !empty && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    push     = valid_in && !below && (!full || pop);
    ts_d     = ts_q + 1'b1;
    seq_d    = push ? seq_q + 1'b1 : seq_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    thr_d    = (valid_in && below) ? sat_inc(thr_q) : thr_q;
    ovf_d    = (valid_in && !below && full && !pop) ? sat_inc(ovf_q) : ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q     <= '0;
      seq_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
      thr_q    <= '0;
    end else begin
      ts_q     <= ts_d;
      seq_q    <= seq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      thr_q    <= thr_d;
    end
  end

  // Storage carries data only; occupancy lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {q_in, ts_q, seq_q};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    out_valid = !empty;
    out_q     = out_valid ? head[EW-1 -: BITS] : '0;
    out_ts    = out_valid ? head[CNT_BITS +: TS_BITS] : '0;
    out_seq   = out_valid ? head[CNT_BITS-1:0] : '0;
    fill      = wr_ptr_q - rd_ptr_q;
    ovf_drops = ovf_q;
    thr_drops = thr_q;
  end

endmodule

// File: tb/tb_q_hit_buffer.sv
// Directed and scoreboard bench for q_hit_buffer, built with a 4-entry FIFO, a 4-bit
// timestamp and 4-bit counters so that the wrap and saturation corners are reachable.
module tb_q_hit_buffer;
  localparam int BITS = 31, TS_BITS = 4, DEPTH_LOG2 = 2, CNT_BITS = 4;

  logic clk = 1'b0;
  logic reset, valid_in, out_ready, out_valid;
  logic signed [BITS-1:0] q_in, q_min, out_q;
  logic [TS_BITS-1:0] out_ts;
  logic [CNT_BITS-1:0] out_seq, ovf_drops, thr_drops;
  logic [DEPTH_LOG2:0] fill;

  q_hit_buffer #(.BITS(BITS), .TS_BITS(TS_BITS), .DEPTH_LOG2(DEPTH_LOG2), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .q_in(q_in), .q_min(q_min),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_ts(out_ts),
    .out_seq(out_seq), .fill(fill), .ovf_drops(ovf_drops), .thr_drops(thr_drops)
  );

  always #5 clk = ~clk;

  // Reference timestamp: the value the DUT should capture in the current cycle.
  logic [TS_BITS-1:0] m_ts;
  always @(posedge clk or posedge reset)
    if (reset) m_ts <= '0;
    else       m_ts <= m_ts + 1'b1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; out_ready = 1'b0; q_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_fill", longint'(fill), 0);
  endtask

  task automatic wait_ts(input int target);
    for (int i = 0; i < 40 && int'(m_ts) != target; i++) tick();
    if (int'(m_ts) != target) begin
      n_chk++;
      $display("FAIL wait_ts: got %0d, expected %0d", m_ts, target);
    end
  endtask

  task automatic hit(input int q);
    valid_in = 1'b1; q_in = BITS'(q);
    tick();
    valid_in = 1'b0;
  endtask

  typedef struct {
    logic v; int q; int qmin; logic rdy;
    logic e_valid; int e_q; int e_seq; int e_fill; int e_ovf; int e_thr;
  } vec_t;

  function automatic vec_t mk(input logic v, input int q, input int qmin, input logic rdy,
                              input logic ev, input int eq, input int es, input int ef,
                              input int eo, input int et);
    vec_t r;
    r.v = v; r.q = q; r.qmin = qmin; r.rdy = rdy; r.e_valid = ev; r.e_q = eq;
    r.e_seq = es; r.e_fill = ef; r.e_ovf = eo; r.e_thr = et;
    return r;
  endfunction

  vec_t tbl[17];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      valid_in = tbl[i].v; q_in = BITS'(tbl[i].q); q_min = BITS'(tbl[i].qmin);
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("row%0d_valid", i), longint'(out_valid), longint'(tbl[i].e_valid));
      chk($sformatf("row%0d_fill", i), longint'(fill), tbl[i].e_fill);
      chk($sformatf("row%0d_ovf", i), longint'(ovf_drops), tbl[i].e_ovf);
      chk($sformatf("row%0d_thr", i), longint'(thr_drops), tbl[i].e_thr);
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_q", i), longint'(out_q), tbl[i].e_q);
        chk($sformatf("row%0d_seq", i), longint'(out_seq), tbl[i].e_seq);
      end
    end
    valid_in = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct { int q; int ts; int seq; } ent_t;
  ent_t sb[$];

  initial begin
    int m_seq, m_ovf, m_thr, hits, v, q;
    logic rdy, pop;
    ent_t e;
    reset = 1'b1; valid_in = 1'b0; out_ready = 1'b0; q_in = '0; q_min = '0;

    // Threshold rows (q_min=50), then overflow rows after a fresh reset.
    tbl[0]  = mk(1, 49, 50, 0,  0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 50, 50, 0,  1, 50, 0, 1, 0, 1);
    tbl[2]  = mk(1, -3, 50, 0,  1, 50, 0, 1, 0, 2);
    tbl[3]  = mk(1, 60, 50, 0,  1, 50, 0, 2, 0, 2);
    tbl[4]  = mk(0, 0, 50, 1,   1, 60, 1, 1, 0, 2);
    tbl[5]  = mk(0, 0, 50, 1,   0, 0, 0, 0, 0, 2);
    tbl[6]  = mk(1, 1, -100, 0, 1, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 2, -100, 0, 1, 1, 0, 2, 0, 0);
    tbl[8]  = mk(1, 3, -100, 0, 1, 1, 0, 3, 0, 0);
    tbl[9]  = mk(1, 4, -100, 0, 1, 1, 0, 4, 0, 0);
    tbl[10] = mk(1, 5, -100, 0, 1, 1, 0, 4, 1, 0);
    tbl[11] = mk(1, 6, -100, 0, 1, 1, 0, 4, 2, 0);
    tbl[12] = mk(1, 7, -100, 1, 1, 2, 1, 4, 2, 0);
    tbl[13] = mk(0, 0, -100, 1, 1, 3, 2, 3, 2, 0);
    tbl[14] = mk(0, 0, -100, 1, 1, 4, 3, 2, 2, 0);
    tbl[15] = mk(0, 0, -100, 1, 1, 7, 4, 1, 2, 0);
    tbl[16] = mk(0, 0, -100, 1, 0, 0, 0, 0, 2, 0);

    // Basic: hits at ts=5 and ts=20 (wraps to 4 with a 4-bit timestamp).
    do_reset();
    chk("rst_ovf", longint'(ovf_drops), 0);
    chk("rst_thr", longint'(thr_drops), 0);
    chk("rst_out_q", longint'(out_q), 0);
    q_min = '0;
    wait_ts(5);  hit(100);
    wait_ts(4);  hit(7);
    chk("basic_fill", longint'(fill), 2);
    chk("basic_valid", longint'(out_valid), 1);
    chk("basic_q0", longint'(out_q), 100);
    chk("basic_ts0", longint'(out_ts), 5);
    chk("basic_seq0", longint'(out_seq), 0);
    out_ready = 1'b1;
    tick();
    chk("basic_q1", longint'(out_q), 7);
    chk("basic_ts1", longint'(out_ts), 4);
    chk("basic_seq1", longint'(out_seq), 1);
    tick();
    chk("basic_empty", longint'(out_valid), 0);
    out_ready = 1'b0;

    do_reset();
    run_rows(0, 5);
    do_reset();
    run_rows(6, 16);

    // Timestamp wrap: ts=15, then a hit two cycles later carries ts=1.
    do_reset();
    q_min = '0;
    wait_ts(15); hit(11);
    tick();      hit(12);
    chk("wrap_ts0", longint'(out_ts), 15);
    out_ready = 1'b1;
    tick();
    chk("wrap_ts1", longint'(out_ts), 1);
    chk("wrap_q1", longint'(out_q), 12);
    out_ready = 1'b0;

    // Saturation: 20 overflow drops and 20 threshold drops both stop at 15.
    do_reset();
    q_min = BITS'(-100);
    for (int i = 0; i < 24; i++) hit(i);
    chk("sat_ovf", longint'(ovf_drops), 15);
    chk("sat_fill", longint'(fill), 4);
    do_reset();
    q_min = BITS'(100);
    for (int i = 0; i < 20; i++) hit(0);
    chk("sat_thr", longint'(thr_drops), 15);
    chk("sat_thr_fill", longint'(fill), 0);

    // Random stalls against a scoreboard.
    do_reset();
    q_min = BITS'(-50000);
    m_seq = 0; m_ovf = 0; m_thr = 0; hits = 0;
    sb.delete();
    for (int cyc = 0; cyc < 20000 && hits < 1000; cyc++) begin
      chk("rnd_valid", longint'(out_valid), longint'(sb.size() > 0));
      chk("rnd_fill", longint'(fill), sb.size());
      if (sb.size() > 0) begin
        chk("rnd_q", longint'(out_q), sb[0].q);
        chk("rnd_ts", longint'(out_ts), sb[0].ts);
        chk("rnd_seq", longint'(out_seq), sb[0].seq);
      end
      v = ($urandom_range(9) < 6) ? 1 : 0;
      q = int'($urandom_range(200000)) - 100000;
      rdy = ($urandom_range(1) == 1);
      valid_in = (v == 1); q_in = BITS'(q); out_ready = rdy;
      pop = (sb.size() > 0) && rdy;
      if (v == 1) begin
        hits++;
        if (q < -50000) m_thr = (m_thr < 15) ? m_thr + 1 : 15;
        else if (sb.size() == 4 && !pop) m_ovf = (m_ovf < 15) ? m_ovf + 1 : 15;
        else begin
          e.q = q; e.ts = int'(m_ts); e.seq = m_seq;
          sb.push_back(e);
          m_seq = (m_seq + 1) % 16;
        end
      end
      if (pop) void'(sb.pop_front());
      tick();
    end
    valid_in = 1'b0; out_ready = 1'b0;
    chk("rnd_hits", hits, 1000);
    chk("rnd_ovf", longint'(ovf_drops), m_ovf);
    chk("rnd_thr", longint'(thr_drops), m_thr);

    // Asynchronous reset between edges with 3 entries and a threshold drop pending.
    do_reset();
    q_min = '0;
    hit(1); hit(2); hit(3); hit(-5);
    chk("ar_pre_fill", longint'(fill), 3);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", longint'(out_valid), 0);
    chk("ar_fill", longint'(fill), 0);
    chk("ar_thr", longint'(thr_drops), 0);
    chk("ar_ovf", longint'(ovf_drops), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    hit(77);
    chk("ar_post_q", longint'(out_q), 77);
    chk("ar_post_seq", longint'(out_seq), 0);
    chk("ar_post_ts", longint'(out_ts), 0);
    chk("ar_post_fill", longint'(fill), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
